// File: rtl/row_accumulator.sv
// Streaming row reduction: sums up to VEC_LEN signed elements into a saturating
// accumulator and presents one registered row sum per row on a valid/ready port.
module row_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int VEC_LEN    = 8,
    parameter int CNT_WIDTH  = $clog2(VEC_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ebl,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_sat
);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(VEC_LEN);

    state_t                 state_reg;
    logic [ACC_WIDTH-1:0]   acc_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic                   sat_reg;

    logic [ACC_WIDTH:0]     data_ext;
    logic [ACC_WIDTH:0]     sum_wide;
    logic                   ovf;
    logic [ACC_WIDTH-1:0]   sum_clamped;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   sat_next;
    logic                   take;
    logic                   end_of_row;

    // in_ready depends only on ebl and registered state, never on in_valid.
    assign in_ready = ebl && (state_reg != OUT);
    assign take     = in_valid && in_ready;

    always_comb begin
        data_ext = {{(ACC_WIDTH + 1 - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
        sum_wide = {acc_reg[ACC_WIDTH-1], acc_reg} + data_ext;
        // One guard bit: the top two bits disagree exactly when the sum left range.
        ovf      = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
        if (!ovf) begin
            sum_clamped = sum_wide[ACC_WIDTH-1:0];
        end else if (sum_wide[ACC_WIDTH]) begin
            sum_clamped = ACC_MIN;
        end else begin
            sum_clamped = ACC_MAX;
        end

        if (state_reg == IDLE) begin
            acc_next = data_ext[ACC_WIDTH-1:0];
            cnt_next = CNT_ONE;
            sat_next = 1'b0;
        end else begin
            acc_next = sum_clamped;
            cnt_next = cnt_reg + CNT_ONE;
            sat_next = sat_reg | ovf;
        end
        end_of_row = in_last || (cnt_next == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, ACC: begin
                    if (take) begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_next;
                        sat_reg <= sat_next;
                        if (end_of_row) begin
                            state_reg <= OUT;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next;
                            out_count <= cnt_next;
                            out_sat   <= sat_next;
                        end else begin
                            state_reg <= ACC;
                        end
                    end
                end
                OUT: begin
                    // Output handshake ignores ebl so a held row can always drain.
                    if (out_ready) begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        sat_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_row_accumulator.sv
// Directed bench for row_accumulator: a 24-bit accumulator instance and a
// 16-bit one fed the same stream so saturation is visible at the narrow width.
module tb_row_accumulator;

    logic        clk;
    logic        rst;
    logic        ebl;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_sat0;
    logic [23:0] out_sum0;
    logic [3:0]  out_count0;
    logic        in_ready1, out_valid1, out_sat1;
    logic [15:0] out_sum1;
    logic [3:0]  out_count1;

    int vectors     = 0;
    int miscompares = 0;

    row_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(24), .VEC_LEN(8)) u_wide (
        .clk(clk), .rst(rst), .ebl(ebl),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .out_count(out_count0), .out_sat(out_sat0)
    );

    row_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(16), .VEC_LEN(8)) u_narrow (
        .clk(clk), .rst(rst), .ebl(ebl),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_sum(out_sum1), .out_count(out_count1), .out_sat(out_sat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Presents one element for exactly one rising edge; returns 1 ns after it.
    task automatic xfer(input logic [15:0] d, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid0); end
        vectors++;
        if (out_sum0 !== 24'd0) begin miscompares++; $display("FAIL reset_sum: got %0h want 0", out_sum0); end
        vectors++;
        if (out_count0 !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", out_count0); end
        vectors++;
        if (out_sat0 !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b want 0", out_sat0); end
        vectors++;
        if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", in_ready0); end
        rst = 1'b0;
    endtask

    task automatic test_full_row();
        for (int i = 1; i <= 8; i++) begin
            xfer(16'(i), 1'b0);
            if (i == 7) begin
                vectors++;
                if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL full_early_valid: got %b want 0", out_valid0); end
            end
        end
        vectors++;
        if (out_valid0 !== 1'b1) begin miscompares++; $display("FAIL full_valid: got %b want 1", out_valid0); end
        vectors++;
        if (out_sum0 !== 24'd36) begin miscompares++; $display("FAIL full_sum: got %0d want 36", $signed(out_sum0)); end
        vectors++;
        if (out_count0 !== 4'd8) begin miscompares++; $display("FAIL full_count: got %0d want 8", out_count0); end
        vectors++;
        if (out_sat0 !== 1'b0) begin miscompares++; $display("FAIL full_sat: got %b want 0", out_sat0); end
        vectors++;
        if (in_ready0 !== 1'b0) begin miscompares++; $display("FAIL full_ready_out: got %b want 0", in_ready0); end
        drain();
        vectors++;
        if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL full_drain_valid: got %b want 0", out_valid0); end
        vectors++;
        if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL full_drain_ready: got %b want 1", in_ready0); end
        vectors++;
        if (out_sum0 !== 24'd36) begin miscompares++; $display("FAIL full_sum_hold: got %0d want 36", $signed(out_sum0)); end
    endtask

    task automatic test_early_last();
        logic [23:0] want;
        want = -24'sd9;
        xfer(-16'sd5, 1'b0);
        xfer(16'sd3, 1'b0);
        xfer(-16'sd7, 1'b1);
        vectors++;
        if (out_valid0 !== 1'b1) begin miscompares++; $display("FAIL early_valid: got %b want 1", out_valid0); end
        vectors++;
        if (out_sum0 !== want) begin miscompares++; $display("FAIL early_sum: got %0h want %0h", out_sum0, want); end
        vectors++;
        if (out_count0 !== 4'd3) begin miscompares++; $display("FAIL early_count: got %0d want 3", out_count0); end
        vectors++;
        if (out_sat0 !== 1'b0) begin miscompares++; $display("FAIL early_sat: got %b want 0", out_sat0); end
        drain();
    endtask

    task automatic test_saturation();
        logic [23:0] want_wide;
        xfer(16'sd32767, 1'b0);
        xfer(16'sd1, 1'b0);
        xfer(-16'sd2, 1'b1);
        vectors++;
        if (out_sum1 !== 16'd32765) begin miscompares++; $display("FAIL sat_pos_sum: got %0d want 32765", $signed(out_sum1)); end
        vectors++;
        if (out_sat1 !== 1'b1) begin miscompares++; $display("FAIL sat_pos_flag: got %b want 1", out_sat1); end
        vectors++;
        if (out_sum0 !== 24'd32766) begin miscompares++; $display("FAIL sat_pos_wide_sum: got %0d want 32766", $signed(out_sum0)); end
        vectors++;
        if (out_sat0 !== 1'b0) begin miscompares++; $display("FAIL sat_pos_wide_flag: got %b want 0", out_sat0); end
        drain();
        xfer(16'h8000, 1'b0);
        xfer(16'hFFFF, 1'b1);
        want_wide = -24'sd32769;
        vectors++;
        if (out_sum1 !== 16'h8000) begin miscompares++; $display("FAIL sat_neg_sum: got %0d want -32768", $signed(out_sum1)); end
        vectors++;
        if (out_sat1 !== 1'b1) begin miscompares++; $display("FAIL sat_neg_flag: got %b want 1", out_sat1); end
        vectors++;
        if (out_count1 !== 4'd2) begin miscompares++; $display("FAIL sat_neg_count: got %0d want 2", out_count1); end
        vectors++;
        if (out_sum0 !== want_wide) begin miscompares++; $display("FAIL sat_neg_wide_sum: got %0h want %0h", out_sum0, want_wide); end
        drain();
    endtask

    task automatic test_backpressure();
        xfer(16'd100, 1'b0);
        xfer(16'd200, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'd999;
            #1;
            vectors++;
            if (out_valid0 !== 1'b1 || out_sum0 !== 24'd300 || out_count0 !== 4'd2 || out_sat0 !== 1'b0)
                begin miscompares++; $display("FAIL bp_hold[%0d]: got v=%b sum=%0d cnt=%0d sat=%b want v=1 sum=300 cnt=2 sat=0",
                                              c, out_valid0, $signed(out_sum0), out_count0, out_sat0); end
            vectors++;
            if (in_ready0 !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b want 0", c, in_ready0); end
        end
        // in_valid stays high across the handshake edge; that element must not be taken.
        drain();
        in_valid = 1'b0;
        vectors++;
        if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL bp_drop_valid: got %b want 0", out_valid0); end
        xfer(16'd5, 1'b1);
        vectors++;
        if (out_sum0 !== 24'd5) begin miscompares++; $display("FAIL bp_next_sum: got %0d want 5", $signed(out_sum0)); end
        vectors++;
        if (out_count0 !== 4'd1) begin miscompares++; $display("FAIL bp_next_count: got %0d want 1", out_count0); end
        drain();
    endtask

    task automatic test_enable_gaps();
        logic [15:0] vals [3];
        int k;
        int cyc;
        vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30;
        k = 0;
        cyc = 0;
        while (k < 3 && cyc < 200) begin
            @(negedge clk);
            ebl      = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = vals[k];
            in_last  = (k == 2);
            #1;
            vectors++;
            if (in_ready0 !== ebl) begin miscompares++; $display("FAIL gap_ready[%0d]: got %b want %b", cyc, in_ready0, ebl); end
            @(posedge clk);
            if (ebl && in_valid) k++;
            cyc++;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        ebl      = 1'b1;
        vectors++;
        if (k != 3) begin miscompares++; $display("FAIL gap_timeout: got %0d elements want 3", k); end
        vectors++;
        if (out_valid0 !== 1'b1) begin miscompares++; $display("FAIL gap_valid: got %b want 1", out_valid0); end
        vectors++;
        if (out_sum0 !== 24'd60) begin miscompares++; $display("FAIL gap_sum: got %0d want 60", $signed(out_sum0)); end
        vectors++;
        if (out_count0 !== 4'd3) begin miscompares++; $display("FAIL gap_count: got %0d want 3", out_count0); end
        // Output side must complete with ebl low.
        ebl = 1'b0;
        drain();
        vectors++;
        if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL gap_drain_ebl0: got %b want 0", out_valid0); end
        ebl = 1'b1;
    endtask

    task automatic test_reset_midrow();
        xfer(16'd9, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid0); end
        vectors++;
        if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL rst_out_idle: got in_ready %b want 1", in_ready0); end
        @(negedge clk);
        rst = 1'b0;
        xfer(16'd4, 1'b0);
        xfer(16'd4, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid0 !== 1'b0 || out_count0 !== 4'd0) begin miscompares++;
            $display("FAIL rst_row_clear: got v=%b cnt=%0d want v=0 cnt=0", out_valid0, out_count0); end
        @(negedge clk);
        rst = 1'b0;
        xfer(16'd7, 1'b1);
        vectors++;
        if (out_sum0 !== 24'd7) begin miscompares++; $display("FAIL rst_next_sum: got %0d want 7", $signed(out_sum0)); end
        vectors++;
        if (out_count0 !== 4'd1) begin miscompares++; $display("FAIL rst_next_count: got %0d want 1", out_count0); end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        ebl       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_full_row();
        test_early_last();
        test_saturation();
        test_backpressure();
        test_enable_gaps();
        test_reset_midrow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/row_accumulator.md
Name: row_accumulator

Overview:
Streaming reduction stage downstream of the pipelined n-bit adder. Consumes one signed DATA_WIDTH result per handshake and accumulates up to VEC_LEN results into a wider signed row sum with saturation, e.g. the softmax denominator or a dot-product partial sum. Emits one registered sum per row over a valid/ready interface to the next attention stage.

Parameters:
DATA_WIDTH, 16, width of each signed input element
ACC_WIDTH, 24, width of the signed accumulator and output sum; must be >= DATA_WIDTH
VEC_LEN, 8, maximum elements per row; must be >= 1
CNT_WIDTH, $clog2(VEC_LEN+1), width of the element counter (derived)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
ebl  input  1  enable; when low no new input is accepted
in_valid  input  1  upstream element valid
in_ready  output  1  block can accept an element
in_data  input  DATA_WIDTH  signed two's-complement element
in_last  input  1  element closes the row early; sampled with the transfer
out_valid  output  1  row sum valid
out_ready  input  1  downstream accepts the row sum
out_sum  output  ACC_WIDTH  signed saturated row sum
out_count  output  CNT_WIDTH  number of elements summed in this row (1..VEC_LEN)
out_sat  output  1  sticky: saturation occurred at least once in this row

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, cnt=0, sat=0, out_valid=0, out_sum=0, out_count=0, out_sat=0. A reset mid-row or mid-output discards the row with no partial output.
- FSM states: IDLE (no row open), ACC (row open), OUT (sum held for downstream).
- in_ready = ebl && (state != OUT). The block applies no combinational path from in_valid to in_ready.
- Input transfer occurs when in_valid && in_ready.
- End-of-row condition: in_last=1, or the new count equals VEC_LEN.
- Transfer in IDLE:
  - acc <= sext(in_data); cnt <= 1; sat <= 0.
  - Next state is OUT on end-of-row, otherwise ACC.
- Transfer in ACC:
  - acc <= sat(acc + sext(in_data)); cnt <= cnt+1; sat <= sat | overflow.
  - Next state is OUT on end-of-row, otherwise ACC.
- No transfer in IDLE or ACC: all state holds. Gaps of any length inside a row are legal.
- Arithmetic:
  - The sum is computed in ACC_WIDTH+1 bits.
  - If the sum is > 2^(ACC_WIDTH-1)-1, the result clamps to the max value. If the sum is < -2^(ACC_WIDTH-1), it clamps to the min value. Either case sets overflow.
  - Once clamped, accumulation continues from the clamped value.
- OUT state:
  - out_valid=1; out_sum=acc, out_count=cnt, out_sat=sat, all registered.
  - Outputs stay stable while out_valid && !out_ready.
  - When out_ready=1: next state is IDLE, out_valid is 0 the next cycle, and acc, cnt and sat clear.
- Output handshake is independent of ebl: OUT completes even with ebl=0.
- Latency: the last element is accepted at edge N, and out_valid is high after edge N.
- Throughput: at least one bubble cycle per row. Input is never accepted in OUT or in the cycle of the output handshake, so the maximum rate is VEC_LEN elements per VEC_LEN+1 cycles.
- Outside OUT: out_sum, out_count and out_sat hold their last values. Only out_valid qualifies them.
- ebl low during ACC: the row stays open, acc holds, and the row resumes when ebl returns high.
- in_last on a transfer whose count also reaches VEC_LEN counts as a single end-of-row.

Test Plan:
- Full row: VEC_LEN=8, ebl=1, in_data 1..8 back-to-back, in_last=0. Required: out_valid one cycle after the 8th transfer, out_sum=36, out_count=8, out_sat=0; in_ready=0 while in OUT.
- Early last with negatives: inputs -5, 3, -7 with in_last on -7. Required: out_sum=-9 (sign-extended to 24 bits), out_count=3, out_sat=0.
- Saturation: ACC_WIDTH=16, DATA_WIDTH=16; inputs 32767, 1, -2 with last on -2. Required: out_sum=32765, out_sat=1. Repeat the row with -32768 and -1: out_sum=-32768, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises. Required: out_sum, out_count and out_sat stable, and in_ready=0 throughout. After out_ready=1, out_valid drops and the next row starts from 0.
- Enable/gaps: toggle ebl and in_valid randomly mid-row with inputs 10, 20, 30 (last). Required: in_ready tracks ebl, no element is lost or double-counted, out_sum=60.
- Reset mid-row: accept 4, 4, then assert rst asynchronously between edges. Required: out_valid=0 immediately and state IDLE. The next row 7 (last) yields out_sum=7, out_count=1.
